// File: rtl/dma_icb_pkg.sv
// Shared definitions for the DMA ICB 2:1 arbiter: payload widths, field
// offsets inside the packed command/response words, and master ids.
package dma_icb_pkg;

    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;

    localparam int CMD_PLD_W = AW_DEF + DW_DEF + DW_DEF / 8 + 1;
    localparam int RSP_PLD_W = DW_DEF + 1;

    // Command word is {read, wmask, wdata, addr}; response word is {err, rdata}.
    localparam int ADDR_LSB  = 0;
    localparam int WDATA_LSB = AW_DEF;
    localparam int WMASK_LSB = AW_DEF + DW_DEF;
    localparam int READ_BIT  = AW_DEF + DW_DEF + DW_DEF / 8;
    localparam int ERR_BIT   = DW_DEF;

    typedef enum logic {
        MST_CPU = 1'b0,
        MST_DMA = 1'b1
    } mst_id_e;

    // The master that should win the next tie after 'id' was served.
    function automatic mst_id_e other_mst(input mst_id_e id);
        other_mst = (id == MST_CPU) ? MST_DMA : MST_CPU;
    endfunction

endpackage

// File: rtl/dma_arbt_fifo.sv
// In-order FIFO of 1-bit master ids, one entry per outstanding slave
// transaction. Pointers carry an extra wrap bit to tell full from empty.
module dma_arbt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [DEPTH-1:0] mem_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                   (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign dout  = mem_r[rd_ptr_r[IDX_W-1:0]];

    // Advance write/read pointers on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Store the pushed id at the write slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= {DEPTH{1'b0}};
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/dma_icb_arbt.sv
// 2:1 ICB arbiter merging the CPU/LSU master (m0) and the DMA data master
// (m1) onto one slave ICB. Zero-latency round-robin command path with a
// presented-command lock; responses are steered back in order through an
// outstanding-id FIFO.
// Build option: define E203_DMA_ARBT_FIXPRIO_EN to make m0 win every tie
// (the round-robin priority register is then removed).
module dma_icb_arbt
    import dma_icb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     m0_icb_cmd_valid,
    output logic                     m0_icb_cmd_ready,
    input  logic [AW+DW+DW/8:0]      m0_icb_cmd_pld,
    output logic                     m0_icb_rsp_valid,
    input  logic                     m0_icb_rsp_ready,
    output logic [DW:0]              m0_icb_rsp_pld,

    input  logic                     m1_icb_cmd_valid,
    output logic                     m1_icb_cmd_ready,
    input  logic [AW+DW+DW/8:0]      m1_icb_cmd_pld,
    output logic                     m1_icb_rsp_valid,
    input  logic                     m1_icb_rsp_ready,
    output logic [DW:0]              m1_icb_rsp_pld,

    output logic                     slv_icb_cmd_valid,
    input  logic                     slv_icb_cmd_ready,
    output logic [AW+DW+DW/8:0]      slv_icb_cmd_pld,
    input  logic                     slv_icb_rsp_valid,
    output logic                     slv_icb_rsp_ready,
    input  logic [DW:0]              slv_icb_rsp_pld,

    output logic                     arbt_idle
);

    mst_id_e grant_s;
    mst_id_e tie_winner_s;
    mst_id_e head_s;
    mst_id_e lock_id_r;
    logic    lock_r;
    logic    granted_valid_s;
    logic    cmd_hs_s;
    logic    rsp_hs_s;
    logic    fifo_full_s;
    logic    fifo_empty_s;
    logic    fifo_dout_s;

`ifdef E203_DMA_ARBT_FIXPRIO_EN
    assign tie_winner_s = MST_CPU;
`else
    mst_id_e prio_r;

    assign tie_winner_s = prio_r;

    // Hand the next tie to the master that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= MST_CPU;
        end else if (cmd_hs_s) begin
            prio_r <= other_mst(grant_s);
        end
    end
`endif

    // Pick the master owning the slave command channel this cycle.
    always_comb begin
        grant_s = MST_CPU;
        if (lock_r) begin
            grant_s = lock_id_r;
        end else if (m0_icb_cmd_valid && !m1_icb_cmd_valid) begin
            grant_s = MST_CPU;
        end else if (!m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            grant_s = MST_DMA;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            grant_s = tie_winner_s;
        end else begin
            grant_s = MST_CPU;
        end
    end

    // Forward the granted command and back-pressure only the granted master.
    always_comb begin
        granted_valid_s  = 1'b0;
        slv_icb_cmd_pld  = m0_icb_cmd_pld;
        m0_icb_cmd_ready = 1'b0;
        m1_icb_cmd_ready = 1'b0;
        case (grant_s)
            MST_CPU: begin
                granted_valid_s  = m0_icb_cmd_valid;
                slv_icb_cmd_pld  = m0_icb_cmd_pld;
                m0_icb_cmd_ready = slv_icb_cmd_ready & ~fifo_full_s;
            end
            MST_DMA: begin
                granted_valid_s  = m1_icb_cmd_valid;
                slv_icb_cmd_pld  = m1_icb_cmd_pld;
                m1_icb_cmd_ready = slv_icb_cmd_ready & ~fifo_full_s;
            end
            default: begin
                granted_valid_s  = 1'b0;
                slv_icb_cmd_pld  = m0_icb_cmd_pld;
            end
        endcase
    end

    assign slv_icb_cmd_valid = granted_valid_s & ~fifo_full_s;
    assign cmd_hs_s          = slv_icb_cmd_valid & slv_icb_cmd_ready;

    // Hold the grant on a presented but unaccepted command until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r    <= 1'b0;
            lock_id_r <= MST_CPU;
        end else if (cmd_hs_s) begin
            lock_r    <= 1'b0;
        end else if (slv_icb_cmd_valid && !slv_icb_cmd_ready) begin
            lock_r    <= 1'b1;
            lock_id_r <= grant_s;
        end
    end

    dma_arbt_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_hs_s),
        .pop   (rsp_hs_s),
        .din   (grant_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_s = mst_id_e'(fifo_dout_s);

    // Steer the slave response to the master at the head of the id FIFO.
    always_comb begin
        m0_icb_rsp_valid  = 1'b0;
        m1_icb_rsp_valid  = 1'b0;
        slv_icb_rsp_ready = 1'b0;
        if (fifo_empty_s) begin
            slv_icb_rsp_ready = 1'b0;
        end else begin
            case (head_s)
                MST_CPU: begin
                    m0_icb_rsp_valid  = slv_icb_rsp_valid;
                    slv_icb_rsp_ready = m0_icb_rsp_ready;
                end
                MST_DMA: begin
                    m1_icb_rsp_valid  = slv_icb_rsp_valid;
                    slv_icb_rsp_ready = m1_icb_rsp_ready;
                end
                default: begin
                    slv_icb_rsp_ready = 1'b0;
                end
            endcase
        end
    end

    assign m0_icb_rsp_pld = slv_icb_rsp_pld;
    assign m1_icb_rsp_pld = slv_icb_rsp_pld;
    assign rsp_hs_s       = slv_icb_rsp_valid & slv_icb_rsp_ready;
    assign arbt_idle      = fifo_empty_s;

endmodule

// File: doc/dma_icb_arbt.md
Name: dma_icb_arbt

Overview:
- 2:1 ICB arbiter placed directly downstream of the DMA data ICB master port.
- Merges the CPU/LSU ICB (m0) and the DMA data ICB (m1) onto one slave ICB toward the system SRAM/bus.
- Command path is zero-latency round-robin.
- An in-order outstanding-ID FIFO routes each slave response back to the master that issued the command.

Parameters:
- AW, 32, address width (matches E203_ADDR_SIZE).
- DW, 32, data width (matches E203_XLEN); wmask width = DW/8.
- OUTS_DEPTH, 4, maximum outstanding slave transactions; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_icb_cmd_valid  in  1  CPU command valid.
- m0_icb_cmd_ready  out  1  CPU command ready.
- m0_icb_cmd_pld  in  AW+DW+DW/8+1  packed {read, wmask, wdata, addr}.
- m0_icb_rsp_valid  out  1  CPU response valid.
- m0_icb_rsp_ready  in  1  CPU response ready.
- m0_icb_rsp_pld  out  DW+1  packed {err, rdata}.
- m1_icb_cmd_valid  in  1  DMA command valid.
- m1_icb_cmd_ready  out  1  DMA command ready.
- m1_icb_cmd_pld  in  AW+DW+DW/8+1  DMA packed command.
- m1_icb_rsp_valid  out  1  DMA response valid.
- m1_icb_rsp_ready  in  1  DMA response ready.
- m1_icb_rsp_pld  out  DW+1  DMA packed response.
- slv_icb_cmd_valid  out  1  merged command valid.
- slv_icb_cmd_ready  in  1  slave command ready.
- slv_icb_cmd_pld  out  AW+DW+DW/8+1  granted master's payload.
- slv_icb_rsp_valid  in  1  slave response valid.
- slv_icb_rsp_ready  out  1  slave response ready.
- slv_icb_rsp_pld  in  DW+1  slave response payload.
- arbt_idle  out  1  high when no transaction is outstanding.

Behaviour:
- Reset: all valid/ready outputs 0, FIFO empty, arbt_idle=1, prio=m0, lock=0, lock_id=0.
- Grant selection:
  - lock=1: grant = lock_id.
  - Else, one valid requester: grant = that requester.
  - Else, both valid: grant = prio.
- slv_icb_cmd_valid = granted master's valid & ~fifo_full.
- slv_icb_cmd_pld = granted payload.
- Granted master's cmd_ready = slv_icb_cmd_ready & ~fifo_full; the other master's cmd_ready = 0.
- Lock: set when slv_icb_cmd_valid & ~slv_icb_cmd_ready, with lock_id = grant; cleared on the command handshake. A presented command therefore never switches master before it completes.
- prio: on every slave command handshake from master k, prio <= ~k.
- Outstanding FIFO (1-bit master id):
  - Push grant id on slave cmd handshake; pop on slave rsp handshake.
  - Full: no push; slv_icb_cmd_valid=0.
  - Full with a simultaneous pop: command still blocked that cycle; accepted the next cycle.
  - Empty with a simultaneous push and pop: not possible; a pop requires a response, and a response requires an earlier push.
- Response routing (combinational, zero latency), head = FIFO head id:
  - m<head>_icb_rsp_valid = slv_icb_rsp_valid & ~fifo_empty; m<head>_icb_rsp_pld = slv_icb_rsp_pld.
  - slv_icb_rsp_ready = m<head>_icb_rsp_ready & ~fifo_empty.
  - The non-head master's rsp_valid is 0.
- Stray response while FIFO empty: slv_icb_rsp_ready=0; never forwarded.
- arbt_idle = fifo_empty.
- Reset mid-operation: FIFO, lock and prio return to reset values; in-flight responses are discarded.

Optional Feature:
- Macro: E203_DMA_ARBT_FIXPRIO_EN.
- Defined: m0 (CPU) always wins ties; the prio register is removed.
- Undefined: round-robin as described under Behaviour.
- The lock rule applies in both builds.

Decomposition:
- Package dma_icb_pkg:
  - CMD_PLD_W, RSP_PLD_W.
  - Field offsets ADDR_LSB, WDATA_LSB, WMASK_LSB, READ_BIT, ERR_BIT.
  - Master ids MST_CPU=0, MST_DMA=1.
- Sub-module dma_arbt_fifo: synchronous id FIFO with ports push, pop, din, dout, full, empty; depth OUTS_DEPTH, pointers one bit wider than log2(OUTS_DEPTH).

Test Plan:
- Single master: m1 writes addr 0x8000_0000, data 0xDEAD_BEEF, slave ready=1 → slv cmd same cycle; response returns on m1 only, m0_rsp_valid=0.
- Contention: m0 and m1 valid every cycle, slave always ready → grants alternate m0, m1, m0, m1 (round-robin), or m0 always (FIXPRIO build).
- Lock: m1 presented, slave ready low for 3 cycles, m0 raises valid in cycle 1 → slv_pld stays m1's until the handshake; m0 is granted next.
- Outstanding limit: slave accepts 4 commands without responding (OUTS_DEPTH=4) → 5th command blocked, arbt_idle=0; one response frees a slot and the 5th command is accepted the next cycle.
- Ordering: interleaved m0, m1, m0 reads with err=1 on the 2nd response → responses delivered to m0, m1, m0 in order; m1 sees err=1.
- Reset asserted with 2 transactions outstanding → FIFO empty, arbt_idle=1, all valids 0 asynchronously.
